// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with next-PC selection and a
// circular return-address stack (RAS) for return-target prediction.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   stall           hold pc, RAS and flags this cycle
//   instruction     instruction at current pc (branch imm [15:0], jump index [25:0])
//   branch/not_eq/zero  conditional branch control (BEQ/BNE)
//   jump, call      J/JAL; call only meaningful together with jump
//   ret, reg_target JR redirect and its register operand
//   pc              current PC register
//   next_pc         combinational PC loaded at the next unstalled edge
//   ras_top         predicted return address (0 when RAS empty)
//   ras_count       number of valid RAS entries
//   ras_overflow    sticky: push while full
//   ras_underflow   sticky: pop while empty
//   ret_mispredict  one-cycle pulse after a ret whose target differed from ras_top
//   align_err       sticky: ret with a misaligned reg_target
module pc_sequencer #(
  parameter int unsigned         XLEN      = 32,
  parameter logic [XLEN-1:0]     RESET_PC  = '0,
  parameter int unsigned         RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic [31:0]     instruction,
  input  logic            branch,
  input  logic            not_eq,
  input  logic            zero,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic [XLEN-1:0] reg_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] ras_top,
  output logic [4:0]      ras_count,
  output logic            ras_overflow,
  output logic            ras_underflow,
  output logic            ret_mispredict,
  output logic            align_err
);

  localparam int unsigned      PTR_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST   = PTR_W'(RAS_DEPTH - 1);
  localparam logic [4:0]       DEPTH5 = 5'(RAS_DEPTH);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] idx_inc;
  logic [PTR_W-1:0] idx_dec;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_offset;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jmp_target;
  logic [XLEN-1:0] ret_target;
  logic            taken;
  logic            do_call;
  logic            do_push;
  logic            do_pop;
  logic            do_repl;
  logic            ras_empty;
  logic            ras_full;

  // Opcode bits are decoded upstream; only the immediate/index fields matter here.
  logic unused_opcode;
  assign unused_opcode = ^instruction[31:26];

  assign pc_plus4   = pc + XLEN'(4);
  assign br_offset  = {{(XLEN-18){instruction[15]}}, instruction[15:0], 2'b00};
  assign br_target  = pc_plus4 + br_offset;
  assign jmp_target = {pc_plus4[XLEN-1:28], instruction[25:0], 2'b00};
  assign ret_target = {reg_target[XLEN-1:2], 2'b00};
  assign taken      = branch & (zero ^ not_eq);

  // call is only a push qualifier for jump; a bare call is ignored.
  assign do_call = jump & call;
  assign do_push = do_call & ~ret;
  assign do_pop  = ret & ~do_call;
  assign do_repl = ret & do_call;

  assign ras_empty = (ras_count == 5'd0);
  assign ras_full  = (ras_count == DEPTH5);
  assign ras_top   = ras_empty ? '0 : ras_mem[top_idx];

  // Explicit wrap so non-power-of-two depths stay circular.
  assign idx_inc = (top_idx == LAST) ? '0 : top_idx + PTR_W'(1);
  assign idx_dec = (top_idx == '0) ? LAST : top_idx - PTR_W'(1);

  always_comb begin
    next_pc = pc_plus4;
    if (ret)
      next_pc = ret_target;
    else if (jump)
      next_pc = jmp_target;
    else if (taken)
      next_pc = br_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      top_idx        <= '0;
      ras_count      <= '0;
      ras_overflow   <= 1'b0;
      ras_underflow  <= 1'b0;
      ret_mispredict <= 1'b0;
      align_err      <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++)
        ras_mem[i] <= '0;
    end else if (stall) begin
      ret_mispredict <= 1'b0;
    end else begin
      pc             <= next_pc;
      ret_mispredict <= ret & ~ras_empty & (ras_top != ret_target);
      if (ret && (reg_target[1:0] != 2'b00))
        align_err <= 1'b1;

      // A combined ret+call on an empty stack behaves as a plain push.
      if (do_push || (do_repl && ras_empty)) begin
        ras_mem[idx_inc] <= pc_plus4;
        top_idx          <= idx_inc;
        if (ras_full)
          ras_overflow <= 1'b1;
        else
          ras_count <= ras_count + 5'd1;
      end else if (do_repl) begin
        ras_mem[top_idx] <= pc_plus4;
      end else if (do_pop) begin
        if (ras_empty) begin
          ras_underflow <= 1'b1;
        end else begin
          ras_count <= ras_count - 5'd1;
          top_idx   <= idx_dec;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vectors, a queue-based reference model
// compared every cycle, and literal expectations at key points.
module tb_pc_sequencer;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall;
  logic [31:0] instruction;
  logic        branch, not_eq, zero, jump, call, ret;
  logic [31:0] reg_target;
  logic [31:0] pc, next_pc, ras_top;
  logic [4:0]  ras_count;
  logic        ras_overflow, ras_underflow, ret_mispredict, align_err;

  always #5 clk = ~clk;

  pc_sequencer #(
    .XLEN(32),
    .RESET_PC(RST_PC),
    .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instruction(instruction),
    .branch(branch), .not_eq(not_eq), .zero(zero), .jump(jump), .call(call),
    .ret(ret), .reg_target(reg_target), .pc(pc), .next_pc(next_pc),
    .ras_top(ras_top), .ras_count(ras_count), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow), .ret_mispredict(ret_mispredict),
    .align_err(align_err)
  );

  // Reference model: newest return address at the back of the queue.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_ovf, m_unf, m_align, m_mis;
  bit          cmp_en = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] m_next();
    logic [31:0] p4;
    int          off;
    p4 = m_pc + 32'd4;
    if (ret) return {reg_target[31:2], 2'b00};
    if (jump) return {p4[31:28], instruction[25:0], 2'b00};
    if (branch && (zero != not_eq)) begin
      off = int'($signed(instruction[15:0]));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  function automatic logic [31:0] m_top();
    if (m_ras.size() == 0) return 32'd0;
    return m_ras[m_ras.size()-1];
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    m_ras.delete();
    m_ovf = 0; m_unf = 0; m_align = 0; m_mis = 0;
  endtask

  task automatic model_commit();
    logic [31:0] nxt;
    logic [31:0] p4;
    if (stall) begin
      m_mis = 0;
    end else begin
      nxt = m_next();
      p4  = m_pc + 32'd4;
      m_mis = ret && (m_ras.size() > 0) && (m_top() != {reg_target[31:2], 2'b00});
      if (ret && reg_target[1:0] != 2'b00) m_align = 1;
      if (jump && call) begin
        if (ret && m_ras.size() > 0) begin
          m_ras[m_ras.size()-1] = p4;
        end else begin
          if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1;
          end
          m_ras.push_back(p4);
        end
      end else if (ret) begin
        if (m_ras.size() > 0) void'(m_ras.pop_back());
        else m_unf = 1;
      end
      m_pc = nxt;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", pc, m_pc);
      chk("next_pc", next_pc, m_next());
      chk("ras_top", ras_top, m_top());
      chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
      chk("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
      chk("ras_underflow", 32'(ras_underflow), 32'(m_unf));
      chk("ret_mispredict", 32'(ret_mispredict), 32'(m_mis));
      chk("align_err", 32'(align_err), 32'(m_align));
    end
  end

  task automatic set_in(input logic st, input logic [31:0] ins, input logic br,
                        input logic ne, input logic z, input logic j, input logic c,
                        input logic r, input logic [31:0] rt);
    stall = st; instruction = ins; branch = br; not_eq = ne; zero = z;
    jump = j; call = c; ret = r; reg_target = rt;
  endtask

  task automatic idle();
    set_in(0, 32'd0, 0, 0, 0, 0, 0, 0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    idle();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    idle();
    model_reset();
    cmp_en = 1'b1;
    #12 rst_n = 1'b1;
    chk("reset pc", pc, 32'h400);
    chk("reset count", 32'(ras_count), 32'd0);

    // Sequential fetch, then asynchronous reset in the middle of a cycle
    step(); chk("seq pc 1", pc, 32'h404);
    step(); chk("seq pc 2", pc, 32'h408);
    step(); chk("seq pc 3", pc, 32'h40C);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("async reset pc", pc, 32'h400);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Jump to 0x100, BEQ taken back to itself, BNE not taken
    set_in(0, 32'h0800_0040, 0, 0, 0, 1, 0, 0, 32'd0);
    step(); chk("j pc", pc, 32'h100);
    set_in(0, 32'h1000_FFFF, 1, 0, 1, 0, 0, 0, 32'd0);
    step(); chk("beq pc", pc, 32'h100);
    set_in(0, 32'h1400_FFFF, 1, 1, 1, 0, 0, 0, 32'd0);
    step(); chk("bne pc", pc, 32'h104);

    // Jump with region bits, stalled then released
    set_in(0, 32'd0, 0, 0, 0, 0, 0, 1, 32'h1000_0010);
    step(); chk("jr far pc", pc, 32'h1000_0010);
    set_in(1, 32'h0800_0040, 0, 0, 0, 1, 0, 0, 32'd0);
    #1 chk("stall next_pc", next_pc, 32'h1000_0100);
    step(); chk("stalled pc", pc, 32'h1000_0010);
    stall = 1'b0;
    step(); chk("j region pc", pc, 32'h1000_0100);
    do_reset();

    // JAL/JR pairing, correct then mispredicted return
    set_in(0, 32'h0800_0080, 0, 0, 0, 1, 0, 0, 32'd0);
    step(); chk("j 0x200", pc, 32'h200);
    set_in(0, 32'h0C00_0100, 0, 0, 0, 1, 1, 0, 32'd0);
    step(); chk("jal count", 32'(ras_count), 32'd1);
    chk("jal top", ras_top, 32'h204);
    set_in(0, 32'd0, 0, 0, 0, 0, 0, 1, 32'h204);
    step(); chk("jr pc", pc, 32'h204);
    chk("jr count", 32'(ras_count), 32'd0);
    chk("jr no mispredict", 32'(ret_mispredict), 32'd0);
    set_in(0, 32'h0800_0080, 0, 0, 0, 1, 0, 0, 32'd0);
    step();
    set_in(0, 32'h0C00_0100, 0, 0, 0, 1, 1, 0, 32'd0);
    step();
    set_in(0, 32'd0, 0, 0, 0, 0, 0, 1, 32'h300);
    step(); chk("jr bad pc", pc, 32'h300);
    chk("mispredict pulse", 32'(ret_mispredict), 32'd1);
    idle();
    step(); chk("mispredict clears", 32'(ret_mispredict), 32'd0);
    do_reset();

    // Overflow by five calls, underflow by five returns
    for (int i = 0; i < 5; i++) begin
      set_in(0, 32'(32'h100 + 4 * (i + 1)), 0, 0, 0, 1, 1, 0, 32'd0);
      step();
    end
    chk("ovf count", 32'(ras_count), 32'd4);
    chk("ovf flag", 32'(ras_overflow), 32'd1);
    chk("ovf top", ras_top, 32'h444);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 32'd0, 0, 0, 0, 0, 0, 1, 32'h900);
      step();
      if (i == 2) chk("oldest lost top", ras_top, 32'h414);
      if (i == 3) begin
        chk("drained count", 32'(ras_count), 32'd0);
        chk("no underflow yet", 32'(ras_underflow), 32'd0);
      end
    end
    chk("underflow flag", 32'(ras_underflow), 32'd1);
    set_in(0, 32'h0C00_0100, 0, 0, 0, 1, 1, 1, 32'h500);
    step(); chk("ret+call pc", pc, 32'h500);
    chk("ret+call count", 32'(ras_count), 32'd1);
    chk("ret+call top", ras_top, 32'h904);
    do_reset();

    // Misaligned return target and PC wrap
    set_in(0, 32'd0, 0, 0, 0, 0, 0, 1, 32'h203);
    step(); chk("misaligned pc", pc, 32'h200);
    chk("align_err set", 32'(align_err), 32'd1);
    idle();
    step(); step(); chk("align_err held", 32'(align_err), 32'd1);
    set_in(0, 32'd0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(); chk("top pc", pc, 32'hFFFF_FFFC);
    idle();
    step(); chk("wrap pc", pc, 32'h0);
    do_reset();
    chk("align_err reset", 32'(align_err), 32'd0);
    step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
